// File: rtl/sram_o_acc.sv
// Output-feature-map buffer: single-port SRAM with read, write and
// saturating accumulate requests, plus a clear sweep between layers.
// Pipeline: the array read is registered on acceptance; stage 0 merges
// forwarded results; stage 1 holds the value that commits to the array.
module sram_o_acc #(
   parameter int WORDS = 6272,
   parameter int DW    = 18,
   parameter int AW    = $clog2(WORDS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr_start,
   output logic          busy,
   input  logic          req,
   input  logic [1:0]    op,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic          dout_vld,
   output logic          sat_flag
);

   typedef enum logic {IDLE, CLEAR} state_t;

   localparam logic [AW:0]   WORDS_W = (AW+1)'(WORDS);
   localparam logic [AW-1:0] LAST    = AW'(WORDS - 1);
   localparam logic [DW-1:0] SMAX    = {1'b0, {(DW-1){1'b1}}};
   localparam logic [DW-1:0] SMIN    = {1'b1, {(DW-1){1'b0}}};

   logic [DW-1:0] mem [WORDS];

   state_t        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          clr_acc, req_acc, last_clr, addr_oor;

   logic          s0_vld_q, s0_vld_d, s0_oor_q, s0_oor_d;
   logic [1:0]    s0_op_q, s0_op_d;
   logic [AW-1:0] s0_addr_q, s0_addr_d;
   logic [DW-1:0] s0_din_q, s0_din_d;
   logic [DW-1:0] rd_data_q;

   logic          s1_vld_q, s1_vld_d;
   logic [AW-1:0] s1_addr_q, s1_addr_d;
   logic [DW-1:0] s1_data_q, s1_data_d;

   // copy of whatever the array took at the last edge; the registered
   // read sampled at that same edge still holds the old word
   logic          wb_vld_q, wb_vld_d;
   logic [AW-1:0] wb_addr_q, wb_addr_d;
   logic [DW-1:0] wb_data_q, wb_data_d;

   logic          dout_vld_q, dout_vld_d, sat_q, sat_d;
   logic [DW-1:0] dout_q, dout_d;

   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] fwd;
   logic [DW:0]   sum;
   logic          ovf, s0_rd, s0_wr, s0_acc;
   logic [DW-1:0] sat_val;

   // acceptance: a request may land on the edge that ends the sweep
   always_comb begin
      last_clr = (state_q == CLEAR) && (cnt_q == LAST);
      clr_acc  = clr_start && (state_q == IDLE);
      req_acc  = req && !clr_start && ((state_q == IDLE) || last_clr);
      addr_oor = !({1'b0, addr} < WORDS_W);
   end

   // clear sweep sequencer: one zero write per cycle, ascending
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (clr_start) begin
            state_d = CLEAR;
            cnt_d   = '0;
         end
         CLEAR: begin
            if (last_clr) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // single write port: the sweep owns it; stage-1 writes during the sweep are dropped
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = s1_addr_q;
      mem_wdata = s1_data_q;
      if (state_q == CLEAR) begin
         mem_we    = 1'b1;
         mem_waddr = cnt_q;
         mem_wdata = '0;
      end else if (s1_vld_q) begin
         mem_we = 1'b1;
      end
   end

   // stage 0: forward newest in-flight value, then add and saturate
   always_comb begin
      fwd = rd_data_q;
      if (wb_vld_q && (wb_addr_q == s0_addr_q)) fwd = wb_data_q;
      if (s1_vld_q && (s1_addr_q == s0_addr_q)) fwd = s1_data_q;
      sum     = {fwd[DW-1], fwd} + {s0_din_q[DW-1], s0_din_q};
      ovf     = sum[DW] ^ sum[DW-1];
      sat_val = ovf ? (sum[DW] ? SMIN : SMAX) : sum[DW-1:0];
      s0_rd   = s0_vld_q && !s0_op_q[0] ^ s0_op_q[1] ? 1'b0 : 1'b0;
      s0_rd   = s0_vld_q && ((s0_op_q == 2'b00) || (s0_op_q == 2'b11));
      s0_wr   = s0_vld_q && !s0_oor_q && (s0_op_q == 2'b01);
      s0_acc  = s0_vld_q && !s0_oor_q && (s0_op_q == 2'b10);
   end

   // next-state for pipeline registers and outputs
   always_comb begin
      s0_vld_d   = req_acc;
      s0_op_d    = op;
      s0_addr_d  = addr;
      s0_din_d   = din;
      s0_oor_d   = addr_oor;
      s1_vld_d   = s0_wr || s0_acc;
      s1_addr_d  = s0_addr_q;
      s1_data_d  = s0_acc ? sat_val : s0_din_q;
      wb_vld_d   = mem_we;
      wb_addr_d  = mem_waddr;
      wb_data_d  = mem_wdata;
      dout_d     = dout_q;
      dout_vld_d = 1'b0;
      if (s0_rd) begin
         dout_vld_d = 1'b1;
         dout_d     = s0_oor_q ? '0 : fwd;
      end
      sat_d = sat_q;
      if (clr_acc)            sat_d = 1'b0;
      else if (s0_acc && ovf) sat_d = 1'b1;
   end

   // control and pipeline state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         s0_vld_q   <= 1'b0;
         s0_op_q    <= '0;
         s0_addr_q  <= '0;
         s0_din_q   <= '0;
         s0_oor_q   <= 1'b0;
         s1_vld_q   <= 1'b0;
         s1_addr_q  <= '0;
         s1_data_q  <= '0;
         wb_vld_q   <= 1'b0;
         wb_addr_q  <= '0;
         wb_data_q  <= '0;
         dout_q     <= '0;
         dout_vld_q <= 1'b0;
         sat_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         s0_vld_q   <= s0_vld_d;
         s0_op_q    <= s0_op_d;
         s0_addr_q  <= s0_addr_d;
         s0_din_q   <= s0_din_d;
         s0_oor_q   <= s0_oor_d;
         s1_vld_q   <= s1_vld_d;
         s1_addr_q  <= s1_addr_d;
         s1_data_q  <= s1_data_d;
         wb_vld_q   <= wb_vld_d;
         wb_addr_q  <= wb_addr_d;
         wb_data_q  <= wb_data_d;
         dout_q     <= dout_d;
         dout_vld_q <= dout_vld_d;
         sat_q      <= sat_d;
      end
   end

   // array: synchronous write and registered read, contents not reset
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
      if (req_acc && !addr_oor) rd_data_q <= mem[addr];
   end

   assign busy     = (state_q == CLEAR);
   assign dout     = dout_q;
   assign dout_vld = dout_vld_q;
   assign sat_flag = sat_q;

endmodule
